dccm_arbiter: RTL
=================

Name: dccm_arbiter

Overview:
- Two-requester arbiter that shares the single-port DCCM SRAM macro between the core-side TL-UL SRAM adapter (port A) and the SPI/boot loader (port B).
- Sits between the requesters and the SRAM macro.
- Grants at most one access per cycle using round-robin arbitration, with a bounded lock that gives port B bursts.
- Routes the SRAM's fixed 1-cycle read data back to the port that issued the read.

Parameters:
- AW, 11, SRAM word address width.
- DW, 32, data and write-mask width.
- MaxLock, 16, maximum consecutive locked port-B grants while port A is pending (must be at least 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- a_req_i  in  1  port A access request.
- a_gnt_o  out  1  port A granted this cycle.
- a_we_i  in  1  port A write enable.
- a_addr_i  in  AW  port A word address.
- a_wdata_i  in  DW  port A write data.
- a_wmask_i  in  DW  port A write bit-mask.
- a_rvalid_o  out  1  port A read data valid.
- a_rdata_o  out  DW  port A read data.
- b_req_i, b_gnt_o, b_we_i, b_addr_i, b_wdata_i, b_wmask_i, b_rvalid_o, b_rdata_o: same as port A, for port B.
- b_lock_i  in  1  port B requests to keep ownership across consecutive cycles.
- mem_req_o  out  1  SRAM access.
- mem_we_o  out  1  SRAM write.
- mem_addr_o  out  AW  SRAM address.
- mem_wdata_o  out  DW  SRAM write data.
- mem_wmask_o  out  DW  SRAM write mask.
- mem_rdata_i  in  DW  SRAM read data, valid 1 cycle after a read.

Behaviour:
- Reset (async, rst_i=1):
  - All registered state clears: last_owner=B (so A wins the first tie), state=RR, lock_cnt=0, rd_pend_a=rd_pend_b=0.
  - a_rvalid_o and b_rvalid_o are 0.
  - a_rdata_o and b_rdata_o are 0.
  - Grants and mem_* outputs are combinational and are 0 whenever there is no request.
- Grant logic:
  - Grant is combinational and issued in the same cycle as the request.
  - At most one of a_gnt_o/b_gnt_o is high in any cycle.
  - mem_req_o = a_gnt_o | b_gnt_o.
  - mem_we_o, mem_addr_o, mem_wdata_o and mem_wmask_o are muxed from the granted port; they are all 0 when neither port is granted.
  - The requester holds its request and payload stable until granted.
- State machine (advances on every grant):
  - RR:
    - Single requester: that requester is granted.
    - Both requesting: grant the port that is not last_owner.
    - Port B granted with b_lock_i=1: go to LOCK_B with lock_cnt=1.
  - LOCK_B:
    - Port B has absolute priority.
    - Each cycle in which B is granted while a_req_i=1 increments lock_cnt; cycles where A is idle do not count.
    - b_lock_i=0, or b_req_i=0: return to RR with lock_cnt=0. The release cycle itself is arbitrated as RR.
    - lock_cnt reaches MaxLock with a_req_i=1: go to FORCE_A.
  - FORCE_A:
    - Grant A for exactly one access, ignoring b_req_i.
    - Then return to LOCK_B with lock_cnt=0 if b_lock_i=1, otherwise return to RR.
    - If a_req_i drops before the grant: return directly using the same rule.
  - last_owner updates to the granted port on every grant.
- Read return:
  - A granted read (we=0) sets rd_pend_x for the following cycle.
  - x_rvalid_o = rd_pend_x, and x_rdata_o = mem_rdata_i while x_rvalid_o=1, otherwise 0.
  - Writes never produce rvalid.
  - Back-to-back reads (for example A then B) return in order, one per cycle. There are no bubbles and no cross-routing.
- Reset mid-operation: an outstanding rd_pend is dropped, and no rvalid is emitted after reset.

Test Plan:
- Reset then a_req only, read addr 0x010:
  - a_gnt_o=1 in the same cycle, mem_addr_o=0x010, mem_we_o=0.
  - a_rvalid_o=1 the next cycle with a_rdata_o = mem_rdata_i; b_rvalid_o stays 0.
- Both ports requesting continuously with no lock:
  - Grants alternate A,B,A,B starting with A.
  - mem_addr_o alternates between the two addresses.
  - rvalids alternate one cycle later.
- b_lock_i=1 and both requesting, MaxLock=16:
  - First 16 grants go to B, the 17th goes to A, then B again.
  - Repeats, so that over 34 cycles there are 32 B grants and 2 A grants.
- Port B write 0xDEADBEEF, mask 0xFFFF0000, to 0x7FF, with A idle:
  - mem_we_o=1, mem_wdata_o=0xDEADBEEF, mem_wmask_o=0xFFFF0000.
  - No rvalid on either port the next cycle.
- Port A read granted, then rst_i asserted in the next cycle before the clock edge:
  - a_rvalid_o drops to 0 immediately.
  - It stays 0 after reset releases, and the next tie is granted to A.
- Lock release: b_lock_i falls while both are requesting in LOCK_B:
  - That cycle follows the RR rule: since B was last_owner, A is granted.

Source files
------------

// File: rtl/dccm_arbiter_if.sv
// Bundles port A, port B and the SRAM macro signals that pass through the DCCM arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the SRAM.
interface dccm_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    logic          a_req_i;
    logic          a_gnt_o;
    logic          a_we_i;
    logic [AW-1:0] a_addr_i;
    logic [DW-1:0] a_wdata_i;
    logic [DW-1:0] a_wmask_i;
    logic          a_rvalid_o;
    logic [DW-1:0] a_rdata_o;

    logic          b_req_i;
    logic          b_gnt_o;
    logic          b_we_i;
    logic          b_lock_i;
    logic [AW-1:0] b_addr_i;
    logic [DW-1:0] b_wdata_i;
    logic [DW-1:0] b_wmask_i;
    logic          b_rvalid_o;
    logic [DW-1:0] b_rdata_o;

    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_wmask_o;
    logic [DW-1:0] mem_rdata_i;

    modport slave (
        input  a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
        output a_gnt_o, a_rvalid_o, a_rdata_o,
        input  b_req_i, b_we_i, b_lock_i, b_addr_i, b_wdata_i, b_wmask_i,
        output b_gnt_o, b_rvalid_o, b_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_rdata_i
    );

    modport master (
        output a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
        input  a_gnt_o, a_rvalid_o, a_rdata_o,
        output b_req_i, b_we_i, b_lock_i, b_addr_i, b_wdata_i, b_wmask_i,
        input  b_gnt_o, b_rvalid_o, b_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dccm_arbiter.sv
// Shares the single-port DCCM SRAM between the core adapter (port A) and the SPI/boot loader (port B).
// Round-robin grants by default; port B may lock the macro for bursts, but after MaxLock locked
// grants while A waits, A is forced one access. Read data returns one cycle later to the issuing port.
module dccm_arbiter #(
    parameter int AW      = 11,
    parameter int DW      = 32,
    parameter int MaxLock = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    dccm_arbiter_if.slave bus
);

    localparam int CntW = $clog2(MaxLock + 1);

    typedef enum logic [1:0] {
        StRr     = 2'd0,
        StLockB  = 2'd1,
        StForceA = 2'd2
    } state_e;

    typedef enum logic {
        OwnerA = 1'b0,
        OwnerB = 1'b1
    } owner_e;

    state_e          state_q, state_d;
    owner_e          lastOwner_q, lastOwner_d;
    logic [CntW-1:0] lockCnt_q, lockCnt_d;
    logic            rdPendA_q, rdPendA_d;
    logic            rdPendB_q, rdPendB_d;

    logic            gntA, gntB;
    logic            rrPickA, rrPickB;
    logic [CntW-1:0] lockCntInc;

    assign lockCntInc = lockCnt_q + CntW'(1);

    // Round-robin choice: a lone requester wins, a tie goes to whoever did not own the last grant.
    always_comb begin
        rrPickA = 1'b0;
        rrPickB = 1'b0;
        if (bus.a_req_i && (!bus.b_req_i || lastOwner_q == OwnerB)) begin
            rrPickA = 1'b1;
        end else if (bus.b_req_i) begin
            rrPickB = 1'b1;
        end
    end

    // Grant selection and state/lock-counter next state; lock release cycles are arbitrated as RR.
    always_comb begin
        gntA      = 1'b0;
        gntB      = 1'b0;
        state_d   = state_q;
        lockCnt_d = lockCnt_q;
        unique case (state_q)
            StRr: begin
                gntA = rrPickA;
                gntB = rrPickB;
                if (rrPickB && bus.b_lock_i) begin
                    lockCnt_d = CntW'(1);
                    state_d   = (bus.a_req_i && MaxLock == 1) ? StForceA : StLockB;
                end
            end
            StLockB: begin
                if (bus.b_req_i && bus.b_lock_i) begin
                    gntB = 1'b1;
                    if (bus.a_req_i) begin
                        lockCnt_d = lockCntInc;
                        if (lockCntInc >= CntW'(MaxLock)) begin
                            state_d = StForceA;
                        end
                    end
                end else begin
                    gntA      = rrPickA;
                    gntB      = rrPickB;
                    lockCnt_d = '0;
                    state_d   = StRr;
                end
            end
            StForceA: begin
                gntA      = bus.a_req_i;
                lockCnt_d = '0;
                state_d   = bus.b_lock_i ? StLockB : StRr;
            end
            default: begin
                lockCnt_d = '0;
                state_d   = StRr;
            end
        endcase
    end

    // Ownership history and read-return tracking follow whichever port was granted this cycle.
    always_comb begin
        lastOwner_d = lastOwner_q;
        if (gntA) begin
            lastOwner_d = OwnerA;
        end else if (gntB) begin
            lastOwner_d = OwnerB;
        end
        rdPendA_d = gntA && !bus.a_we_i;
        rdPendB_d = gntB && !bus.b_we_i;
    end

    // Arbiter state registers; reset leaves A to win the first tie and drops any outstanding read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRr;
            lastOwner_q <= OwnerB;
            lockCnt_q   <= '0;
            rdPendA_q   <= 1'b0;
            rdPendB_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
            lockCnt_q   <= lockCnt_d;
            rdPendA_q   <= rdPendA_d;
            rdPendB_q   <= rdPendB_d;
        end
    end

    // SRAM request mux; every field is forced to zero when nobody is granted.
    always_comb begin
        bus.mem_req_o   = gntA || gntB;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = {AW{1'b0}};
        bus.mem_wdata_o = {DW{1'b0}};
        bus.mem_wmask_o = {DW{1'b0}};
        if (gntA) begin
            bus.mem_we_o    = bus.a_we_i;
            bus.mem_addr_o  = bus.a_addr_i;
            bus.mem_wdata_o = bus.a_wdata_i;
            bus.mem_wmask_o = bus.a_wmask_i;
        end else if (gntB) begin
            bus.mem_we_o    = bus.b_we_i;
            bus.mem_addr_o  = bus.b_addr_i;
            bus.mem_wdata_o = bus.b_wdata_i;
            bus.mem_wmask_o = bus.b_wmask_i;
        end
    end

    // Grant and read-return outputs; read data is gated so a port only ever sees its own return.
    always_comb begin
        bus.a_gnt_o    = gntA;
        bus.b_gnt_o    = gntB;
        bus.a_rvalid_o = rdPendA_q;
        bus.b_rvalid_o = rdPendB_q;
        bus.a_rdata_o  = rdPendA_q ? bus.mem_rdata_i : {DW{1'b0}};
        bus.b_rdata_o  = rdPendB_q ? bus.mem_rdata_i : {DW{1'b0}};
    end

endmodule
